// File: rtl/drv_sgmnt_pkg.sv
// -----------------------------------------------------------------------------
// drv_sgmnt_pkg
// Shared types and constants for the display driver (drv_sgmnt_fx) and its
// BCD-to-segment decoder.
//   state_t   : display FSM states (IDLE, BLINK, FLASH)
//   SEG_DASH  : pattern shown for non-BCD codes 10..15 (segment g only)
//   SEG_BLANK : all segments off, before polarity inversion
//   SEG_TABLE : 16-entry BCD-to-segment table, bit order gfedcba
// -----------------------------------------------------------------------------
package drv_sgmnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    FLASH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Element [15] is listed first; codes 10..15 all map to a dash.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/drv_sgmnt_decoder.sv
// -----------------------------------------------------------------------------
// drv_sgmnt_decoder
// Combinational BCD-to-7-segment decoder, active-high (1 = segment lit).
//   i_bcd  in  [3:0]  BCD code; 10..15 decode to a dash
//   o_seg  out [6:0]  segment pattern, bit order gfedcba
// -----------------------------------------------------------------------------
module drv_sgmnt_decoder
  import drv_sgmnt_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_bcd];

endmodule

// File: rtl/drv_sgmnt_fx.sv
// -----------------------------------------------------------------------------
// drv_sgmnt_fx
// Output-side display driver for one player panel: two 7-segment digits plus
// four LEDs, with a continuous blink mode and a one-shot flash sequence.
//
// Parameters
//   p_divider     clock cycles per blink/flash half-period (>= 2)
//   p_flash_count dark/lit pairs per flash sequence (>= 1)
//   p_mode        "active_high" (1 = lit) or "active_low" (0 = lit)
//
// Ports
//   i_clk        in  1        system clock
//   i_rst        in  1        synchronous reset, active-high
//   i_digit      in  [1:0][3:0] BCD digits, [1] = tens, [0] = units
//   i_led        in  [3:0]    requested LED levels, 1 = lit
//   i_blink      in  1        blink the display while high
//   i_flash      in  1        single-cycle pulse, (re)starts a flash sequence
//   o_drv_sgmnt  out [1:0][6:0] segment outputs, gfedcba, registered
//   o_drv_led    out [3:0]    LED outputs, registered
//   o_busy       out 1        high while a flash sequence runs, registered
// -----------------------------------------------------------------------------
module drv_sgmnt_fx
  import drv_sgmnt_pkg::*;
#(
  parameter int unsigned p_divider     = 12_500_000,
  parameter int unsigned p_flash_count = 3,
  parameter string       p_mode        = "active_high"
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0][3:0] i_digit,
  input  logic [3:0]      i_led,
  input  logic            i_blink,
  input  logic            i_flash,
  output logic [1:0][6:0] o_drv_sgmnt,
  output logic [3:0]      o_drv_led,
  output logic            o_busy
);

  localparam int unsigned PRESC_W = (p_divider > 1) ? $clog2(p_divider) : 1;
  localparam int unsigned HALF_N  = 2 * p_flash_count;
  localparam int unsigned HALF_W  = (HALF_N > 1) ? $clog2(HALF_N) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(p_divider - 1);
  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(HALF_N - 1);

  localparam bit          INVERT  = (p_mode == "active_low");
  localparam logic [13:0] INV_SEG = {14{INVERT}};
  localparam logic [3:0]  INV_LED = {4{INVERT}};

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [HALF_W-1:0]  half_q,  half_d;
  logic               phase_q, phase_d;
  logic               tick;
  logic               lit_d;
  logic [1:0][6:0]    seg_dec;

  drv_sgmnt_decoder u_dec_units (.i_bcd(i_digit[0]), .o_seg(seg_dec[0]));
  drv_sgmnt_decoder u_dec_tens  (.i_bcd(i_digit[1]), .o_seg(seg_dec[1]));

  assign tick = (presc_q == PRESC_LAST);

  // Next-state logic. Every sequence entry clears the timebase so the first
  // half-period is always dark and exactly p_divider cycles long.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path through
    // this block can leave one unassigned and infer a latch.
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    half_d  = half_q;

    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        phase_d = 1'b0;
        half_d  = '0;
        if (i_flash) begin
          state_d = FLASH;
        end else if (i_blink) begin
          state_d = BLINK;
        end
      end

      BLINK: begin
        if (i_flash) begin
          state_d = FLASH;
          presc_d = '0;
          phase_d = 1'b0;
          half_d  = '0;
        end else if (!i_blink) begin
          state_d = IDLE;
          presc_d = '0;
          phase_d = 1'b0;
        end else begin
          presc_d = tick ? '0 : presc_q + PRESC_W'(1);
          phase_d = phase_q ^ tick;
        end
      end

      FLASH: begin
        if (i_flash) begin
          // Retrigger: restart the whole sequence, busy stays high.
          presc_d = '0;
          phase_d = 1'b0;
          half_d  = '0;
        end else if (tick && (half_q == HALF_LAST)) begin
          // i_blink is only looked at here, at the end of the sequence.
          state_d = i_blink ? BLINK : IDLE;
          presc_d = '0;
          phase_d = 1'b0;
          half_d  = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PRESC_W'(1);
          phase_d = phase_q ^ tick;
          half_d  = tick ? half_q + HALF_W'(1) : half_q;
        end
      end

      default: begin
        state_d = IDLE;
        presc_d = '0;
        phase_d = 1'b0;
        half_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so a transition shows on the
  // very next cycle, while digit/LED values are sampled every cycle.
  assign lit_d = (state_d == IDLE) || phase_d;

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      phase_q     <= 1'b0;
      half_q      <= '0;
      // Reset drives the unlit level, which is all-ones in active_low mode.
      o_drv_sgmnt <= INV_SEG;
      o_drv_led   <= INV_LED;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      half_q      <= half_d;
      o_drv_sgmnt <= (lit_d ? seg_dec : {SEG_BLANK, SEG_BLANK}) ^ INV_SEG;
      o_drv_led   <= (lit_d ? i_led : 4'b0000) ^ INV_LED;
      o_busy      <= (state_d == FLASH);
    end
  end

endmodule

// File: tb/tb_drv_sgmnt_fx.sv
// -----------------------------------------------------------------------------
// tb_drv_sgmnt_fx
// Bench for drv_sgmnt_fx with p_divider = 4, p_flash_count = 2. Two instances
// (active_high and active_low) share all inputs. The reference model tracks
// the display mode and the number of cycles spent in it; lit/dark follows
// from elapsed time divided by the half-period.
// -----------------------------------------------------------------------------
module tb_drv_sgmnt_fx;

  localparam int DIV       = 4;
  localparam int FC        = 2;
  localparam int FLASH_LEN = 2 * FC * DIV;

  typedef enum {M_IDLE, M_BLINK, M_FLASH} mode_e;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][3:0] digit;
  logic [3:0]      led;
  logic            blink;
  logic            flash;

  logic [1:0][6:0] seg_h, seg_l;
  logic [3:0]      led_h, led_l;
  logic            busy_h, busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  drv_sgmnt_fx #(.p_divider(DIV), .p_flash_count(FC), .p_mode("active_high")) dut_h (
    .i_clk(clk), .i_rst(rst), .i_digit(digit), .i_led(led), .i_blink(blink),
    .i_flash(flash), .o_drv_sgmnt(seg_h), .o_drv_led(led_h), .o_busy(busy_h)
  );

  drv_sgmnt_fx #(.p_divider(DIV), .p_flash_count(FC), .p_mode("active_low")) dut_l (
    .i_clk(clk), .i_rst(rst), .i_digit(digit), .i_led(led), .i_blink(blink),
    .i_flash(flash), .o_drv_sgmnt(seg_l), .o_drv_led(led_l), .o_busy(busy_l)
  );

  // Observed vectors {busy, led, seg}; the active_low copy is re-inverted so
  // both compare against the same expectation.
  logic [18:0] obs_h, obs_l;
  assign obs_h = {busy_h, led_h, seg_h};
  assign obs_l = {busy_l, ~led_l, ~seg_l};

  // ---------------------------------------------------------------- model
  mode_e           m_mode  = M_IDLE;
  int              m_t     = 0;     // cycles already spent in m_mode
  bit              m_blank = 1'b1;  // first cycle after a sampled reset
  logic [1:0][3:0] m_dig   = '0;
  logic [3:0]      m_led   = '0;

  function automatic logic [6:0] ref_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode  <= M_IDLE;
      m_t     <= 0;
      m_blank <= 1'b1;
    end else begin
      m_blank <= 1'b0;
      m_dig   <= digit;
      m_led   <= led;
      case (m_mode)
        M_IDLE: begin
          if (flash)      begin m_mode <= M_FLASH; m_t <= 0; end
          else if (blink) begin m_mode <= M_BLINK; m_t <= 0; end
        end
        M_BLINK: begin
          if (flash)       begin m_mode <= M_FLASH; m_t <= 0; end
          else if (!blink) begin m_mode <= M_IDLE;  m_t <= 0; end
          else m_t <= m_t + 1;
        end
        default: begin
          if (flash) m_t <= 0;
          else if (m_t == FLASH_LEN - 1) begin
            m_mode <= blink ? M_BLINK : M_IDLE;
            m_t    <= 0;
          end else m_t <= m_t + 1;
        end
      endcase
    end
  end

  function automatic logic [18:0] model_out();
    logic lit;
    lit = !m_blank && ((m_mode == M_IDLE) || (((m_t / DIV) % 2) == 1));
    return {m_mode == M_FLASH,
            lit ? m_led : 4'b0000,
            lit ? {ref_decode(m_dig[1]), ref_decode(m_dig[0])} : 14'b0};
  endfunction

  // ---------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    digit[1] = 4'($urandom_range(15, 0));
    digit[0] = 4'($urandom_range(15, 0));
    led      = 4'($urandom_range(15, 0));
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; digit = {4'd1, 4'd0}; led = 4'b1011; blink = 1'b0; flash = 1'b0;
    step();
    step();
    n_checks++;
    if (obs_h !== 19'h0 || {busy_h, led_h, seg_h} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_high: got %h, want 00000", {busy_h, led_h, seg_h});
    end
    n_checks++;
    if ({busy_l, led_l, seg_l} !== 19'h3ffff) begin
      n_fail++;
      $display("FAIL reset_low: got %h, want 3ffff", {busy_l, led_l, seg_l});
    end
    rst = 1'b0;
    n_checks++;
    if (seg_h !== 14'h0 || led_h !== 4'h0) begin
      n_fail++;
      $display("FAIL release_first_cycle: seg %h led %h, want unlit", seg_h, led_h);
    end
    step();
    n_checks++;
    if (seg_h[1] !== 7'b0000110 || seg_h[0] !== 7'b0111111 || led_h !== 4'b1011) begin
      n_fail++;
      $display("FAIL release_decode_high: seg %b_%b led %b, want 0000110_0111111 1011",
               seg_h[1], seg_h[0], led_h);
    end
    n_checks++;
    if (seg_l[1] !== 7'b1111001 || seg_l[0] !== 7'b1000000 || led_l !== 4'b0100) begin
      n_fail++;
      $display("FAIL release_decode_low: seg %b_%b led %b, want 1111001_1000000 0100",
               seg_l[1], seg_l[0], led_l);
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 16; i++) begin
      digit[0] = 4'(i);
      digit[1] = 4'($urandom_range(15, 0));
      led      = 4'($urandom_range(15, 0));
      step();
      n_checks++;
      if (obs_h !== model_out()) begin
        n_fail++;
        $display("FAIL decode_high code %0d: got %h want %h", i, obs_h, model_out());
      end
      n_checks++;
      if (obs_l !== model_out()) begin
        n_fail++;
        $display("FAIL decode_low code %0d: got %h want %h", i, obs_l, model_out());
      end
      if (i == 12) begin
        n_checks++;
        if (seg_h[0] !== 7'b1000000) begin
          n_fail++;
          $display("FAIL invalid_digit: got %b want 1000000", seg_h[0]);
        end
      end
    end
  endtask

  task automatic test_blink();
    digit = {4'd4, 4'd7}; led = 4'b0110;
    blink = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 10) rand_data();  // change mid-blink; timing must not restart
      if (k < 4) begin
        n_checks++;
        if (seg_h !== 14'h0 || led_h !== 4'h0) begin
          n_fail++;
          $display("FAIL blink_first_dark cyc %0d: seg %h led %h", k, seg_h, led_h);
        end
      end
      n_checks++;
      if (obs_h !== model_out() || obs_l !== model_out()) begin
        n_fail++;
        $display("FAIL blink cyc %0d: high %h low %h want %h", k, obs_h, obs_l, model_out());
      end
    end
    blink = 1'b0;
    step();
    n_checks++;
    if (seg_h !== {ref_decode(digit[1]), ref_decode(digit[0])} || led_h !== led) begin
      n_fail++;
      $display("FAIL blink_release: seg %h led %h, want lit", seg_h, led_h);
    end
  endtask

  task automatic test_flash();
    int cnt;
    blink = 1'b0;
    flash = 1'b1;
    step();
    flash = 1'b0;
    cnt = 0;
    while (busy_h === 1'b1 && cnt < 40) begin
      n_checks++;
      if (obs_h !== model_out() || obs_l !== model_out()) begin
        n_fail++;
        $display("FAIL flash cyc %0d: high %h low %h want %h", cnt, obs_h, obs_l, model_out());
      end
      if (cnt == 9) rand_data();
      cnt++;
      step();
    end
    n_checks++;
    if (cnt !== FLASH_LEN) begin
      n_fail++;
      $display("FAIL flash_length: busy for %0d cycles, want %0d", cnt, FLASH_LEN);
    end
    n_checks++;
    if (busy_h !== 1'b0 || seg_h !== {ref_decode(digit[1]), ref_decode(digit[0])}) begin
      n_fail++;
      $display("FAIL flash_end_idle: busy %b seg %h, want 0 and lit", busy_h, seg_h);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    blink = 1'b1;
    flash = 1'b1;
    step();
    flash = 1'b0;
    n_checks++;
    if (busy_h !== 1'b1 || seg_h !== 14'h0) begin
      n_fail++;
      $display("FAIL flash_priority: busy %b seg %h, want 1 and dark", busy_h, seg_h);
    end
    for (int k = 1; k < 6; k++) step();
    flash = 1'b1;  // sampled at the end of the 6th flash cycle
    step();
    flash = 1'b0;
    cnt = 0;
    while (busy_h === 1'b1 && cnt < 40) begin
      n_checks++;
      if (obs_h !== model_out()) begin
        n_fail++;
        $display("FAIL retrigger cyc %0d: got %h want %h", cnt, obs_h, model_out());
      end
      cnt++;
      step();
    end
    n_checks++;
    if (cnt !== FLASH_LEN) begin
      n_fail++;
      $display("FAIL retrigger_length: busy for %0d cycles, want %0d", cnt, FLASH_LEN);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (seg_h !== 14'h0 || busy_h !== 1'b0) begin
        n_fail++;
        $display("FAIL flash_to_blink_dark cyc %0d: seg %h busy %b", k, seg_h, busy_h);
      end
      step();
    end
    n_checks++;
    if (seg_h !== {ref_decode(digit[1]), ref_decode(digit[0])}) begin
      n_fail++;
      $display("FAIL flash_to_blink_lit: seg %h", seg_h);
    end
    blink = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_flash();
    flash = 1'b1;
    step();
    flash = 1'b0;
    for (int k = 1; k < 10; k++) step();  // now in the 10th flash cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (busy_h !== 1'b0 || seg_h !== 14'h0 || led_h !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_flash_high: busy %b seg %h led %h", busy_h, seg_h, led_h);
    end
    n_checks++;
    if (busy_l !== 1'b0 || seg_l !== 14'h3fff || led_l !== 4'hf) begin
      n_fail++;
      $display("FAIL reset_mid_flash_low: busy %b seg %h led %h", busy_l, seg_l, led_l);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (busy_h !== 1'b0 || obs_h !== model_out()) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %h want %h", k, obs_h, model_out());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rand_data();
      if ($urandom_range(9, 0) == 0) blink = ~blink;
      flash = ($urandom_range(19, 0) == 0);
      rst   = ($urandom_range(99, 0) == 0);
      step();
      n_checks++;
      if (obs_h !== model_out() || obs_l !== model_out()) begin
        n_fail++;
        $display("FAIL random cyc %0d: high %h low %h want %h", k, obs_h, obs_l, model_out());
      end
    end
    rst = 1'b0; flash = 1'b0; blink = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_blink();
    test_flash();
    test_back_to_back();
    test_reset_mid_flash();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
